// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : fetch_seq
// Description : Instruction fetch and microcode step sequencer. Fetches the
//               opcode and up to two operand bytes over a byte-wide req/ack
//               handshake, then steps the microcode index under decoder
//               control. Halts on trap, illegal length or step overflow and
//               resumes on an external pulse.
// Options     : FETCH_SEQ_SINGLE_STEP_EN adds i_step_en. When i_step_en is
//               high, the end of each instruction parks the FSM in HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq (
  input  logic       clk,
  input  logic       rst,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  input  logic       i_step_en,
`endif
  output logic       o_fetch_req,
  input  logic       i_fetch_ack,
  input  logic [7:0] i_fetch_data,
  output logic       o_pc_adv,
  input  logic [1:0] i_len,
  input  logic       i_pc_cub,
  input  logic       i_pc_ini,
  input  logic       i_pc_lrc,
  input  logic       i_trap,
  input  logic       i_resume,
  output logic [7:0] o_insn,
  output logic [7:0] o_d1,
  output logic [7:0] o_d2,
  output logic [2:0] o_is,
  output logic       o_busy,
  output logic [1:0] o_fault
);

  // Fault codes reported on o_fault
  localparam logic [1:0] c_FAULT_NONE    = 2'd0;
  localparam logic [1:0] c_FAULT_TRAP    = 2'd1;
  localparam logic [1:0] c_FAULT_ILLEGAL = 2'd2;
  localparam logic [1:0] c_FAULT_OVF     = 2'd3;

  // Decoded instruction lengths (illegal code 3 is handled by the default arm)
  localparam logic [1:0] c_LEN_1B = 2'd0;
  localparam logic [1:0] c_LEN_2B = 2'd1;
  localparam logic [1:0] c_LEN_3B = 2'd2;

  localparam logic [2:0] c_IS_MAX = 3'd7;

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_F_OP = 3'd1,
    ST_DEC  = 3'd2,
    ST_F_D1 = 3'd3,
    ST_F_D2 = 3'd4,
    ST_EXEC = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_insn;
  logic [7:0] r_d1;
  logic [7:0] r_d2;
  logic [2:0] r_is;
  logic [1:0] r_fault;
  logic [1:0] r_len;
  logic       r_pc_adv;

  logic [2:0] w_is_nxt;
  logic [1:0] w_fault_nxt;
  logic       w_req;
  logic       w_xfer;
  logic       w_ld_insn;
  logic       w_ld_d1;
  logic       w_ld_d2;
  logic       w_ld_len;
  logic       w_end_insn_halt;

`ifdef FETCH_SEQ_SINGLE_STEP_EN
  // Single-step parks the sequencer in HALT at every instruction boundary
  assign w_end_insn_halt = i_step_en;
`else
  assign w_end_insn_halt = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, handshake request and datapath load strobes
  always_comb begin
    w_state_nxt = r_state;
    w_is_nxt    = r_is;
    w_fault_nxt = r_fault;
    w_req       = 1'b0;
    w_ld_insn   = 1'b0;
    w_ld_d1     = 1'b0;
    w_ld_d2     = 1'b0;
    w_ld_len    = 1'b0;

    case (r_state)
      ST_RST: begin
        w_state_nxt = ST_F_OP;
      end

      ST_F_OP: begin
        w_req = 1'b1;
        if (i_fetch_ack) begin
          w_ld_insn   = 1'b1;
          w_is_nxt    = 3'd0;
          w_state_nxt = ST_DEC;
        end
      end

      ST_DEC: begin
        w_ld_len = 1'b1;
        case (i_len)
          c_LEN_1B: w_state_nxt = ST_EXEC;
          c_LEN_2B,
          c_LEN_3B: w_state_nxt = ST_F_D1;
          default: begin
            w_state_nxt = ST_HALT;
            w_fault_nxt = c_FAULT_ILLEGAL;
          end
        endcase
      end

      ST_F_D1: begin
        w_req = 1'b1;
        if (i_fetch_ack) begin
          w_ld_d1     = 1'b1;
          w_state_nxt = (r_len == c_LEN_3B) ? ST_F_D2 : ST_EXEC;
        end
      end

      ST_F_D2: begin
        w_req = 1'b1;
        if (i_fetch_ack) begin
          w_ld_d2     = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end

      // Priority: trap > step overflow > lrc/ini > cub; otherwise wait
      ST_EXEC: begin
        if (i_trap) begin
          w_state_nxt = ST_HALT;
          w_fault_nxt = c_FAULT_TRAP;
        end else if (i_pc_cub && (r_is == c_IS_MAX)) begin
          w_state_nxt = ST_HALT;
          w_fault_nxt = c_FAULT_OVF;
        end else if (i_pc_lrc || i_pc_ini) begin
          w_is_nxt    = 3'd0;
          w_fault_nxt = c_FAULT_NONE;
          w_state_nxt = w_end_insn_halt ? ST_HALT : ST_F_OP;
        end else if (i_pc_cub) begin
          w_is_nxt = r_is + 3'd1;
        end
      end

      ST_HALT: begin
        if (i_resume) begin
          w_state_nxt = ST_F_OP;
          w_fault_nxt = c_FAULT_NONE;
          w_is_nxt    = 3'd0;
        end
      end

      default: begin
        w_state_nxt = ST_RST;
      end
    endcase
  end

  // A transfer only counts while we are actually requesting
  assign w_xfer = w_req & i_fetch_ack;

  // Instruction bytes, latched length, step index and fault code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_insn  <= 8'd0;
      r_d1    <= 8'd0;
      r_d2    <= 8'd0;
      r_is    <= 3'd0;
      r_fault <= c_FAULT_NONE;
      r_len   <= 2'd0;
    end else begin
      r_is    <= w_is_nxt;
      r_fault <= w_fault_nxt;
      if (w_ld_len) begin
        r_len <= i_len;
      end
      if (w_ld_insn) begin
        r_insn <= i_fetch_data;
        r_d1   <= 8'd0;
        r_d2   <= 8'd0;
      end
      if (w_ld_d1) begin
        r_d1 <= i_fetch_data;
      end
      if (w_ld_d2) begin
        r_d2 <= i_fetch_data;
      end
    end
  end

  // One-cycle PC advance pulse following each accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_adv <= 1'b0;
    end else begin
      r_pc_adv <= w_xfer;
    end
  end

  assign o_fetch_req = w_req;
  assign o_pc_adv    = r_pc_adv;
  assign o_insn      = r_insn;
  assign o_d1        = r_d1;
  assign o_d2        = r_d2;
  assign o_is        = r_is;
  assign o_fault     = r_fault;
  assign o_busy      = (r_state != ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_seq
// Description : Directed self-checking bench for fetch_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_req;
  logic       fetch_ack;
  logic [7:0] fetch_data;
  logic       pc_adv;
  logic [1:0] len;
  logic       pc_cub, pc_ini, pc_lrc, trap, resume;
  logic [7:0] insn, d1, d2;
  logic [2:0] is_q;
  logic       busy;
  logic [1:0] fault;

  int checks   = 0;
  int failures = 0;
  int adv_cnt  = 0;

  always #5 clk = ~clk;

  fetch_seq dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    .i_step_en    (1'b0),
`endif
    .o_fetch_req  (fetch_req),
    .i_fetch_ack  (fetch_ack),
    .i_fetch_data (fetch_data),
    .o_pc_adv     (pc_adv),
    .i_len        (len),
    .i_pc_cub     (pc_cub),
    .i_pc_ini     (pc_ini),
    .i_pc_lrc     (pc_lrc),
    .i_trap       (trap),
    .i_resume     (resume),
    .o_insn       (insn),
    .o_d1         (d1),
    .o_d2         (d2),
    .o_is         (is_q),
    .o_busy       (busy),
    .o_fault      (fault)
  );

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (pc_adv === 1'b1) adv_cnt++;
  endtask

  // Present a byte after dly wait cycles, then complete the transfer
  task automatic fetch_byte(input logic [7:0] b, input int dly);
    repeat (dly) tick();
    fetch_ack = 1'b1; fetch_data = b;
    tick();
    fetch_ack = 1'b0; fetch_data = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_ack = 0; fetch_data = 0; len = 0;
    pc_cub = 0; pc_ini = 0; pc_lrc = 0; trap = 0; resume = 0;
    #1;
    checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b want=0", fetch_req); end
    checks++; if (pc_adv !== 1'b0) begin failures++; $display("FAIL rst_adv got=%b want=0", pc_adv); end
    checks++; if ({insn, d1, d2} !== 24'h0) begin failures++; $display("FAIL rst_bytes got=%h want=000000", {insn, d1, d2}); end
    checks++; if ({is_q, fault} !== 5'd0) begin failures++; $display("FAIL rst_is_fault got=%b want=00000", {is_q, fault}); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b want=1", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_one_byte();
    tick();  // RST -> F_OP
    checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL op_req got=%b want=1", fetch_req); end
    fetch_ack = 1'b1; fetch_data = 8'h3C;
    tick();  // transfer -> DEC
    fetch_ack = 1'b0;
    checks++; if (insn !== 8'h3C) begin failures++; $display("FAIL op_insn got=%h want=3c", insn); end
    checks++; if (pc_adv !== 1'b1) begin failures++; $display("FAIL op_adv got=%b want=1", pc_adv); end
    checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL dec_req got=%b want=0", fetch_req); end
    len = 2'd0;
    tick();  // DEC -> EXEC
    checks++; if (pc_adv !== 1'b0) begin failures++; $display("FAIL adv_pulse got=%b want=0", pc_adv); end
    checks++; if ({d1, d2, is_q} !== 19'd0) begin failures++; $display("FAIL exec_init got=%h want=0", {d1, d2, is_q}); end
    checks++; if ({fetch_req, busy} !== 2'b01) begin failures++; $display("FAIL exec_ctl got=%b want=01", {fetch_req, busy}); end
  endtask

  task automatic test_exec_steps();
    resume = 1'b1;  // ignored outside HALT; also a wait cycle
    tick();
    resume = 1'b0;
    checks++; if ({fetch_req, is_q} !== 4'b0000) begin failures++; $display("FAIL resume_ign got=%b want=0000", {fetch_req, is_q}); end
    pc_cub = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (is_q !== 3'(i)) begin failures++; $display("FAIL step%0d got=%0d want=%0d", i, is_q, i); end
    end
    pc_cub = 1'b0; pc_ini = 1'b1;
    tick();
    pc_ini = 1'b0;
    checks++; if (is_q !== 3'd0) begin failures++; $display("FAIL ini_is got=%0d want=0", is_q); end
    checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL ini_req got=%b want=1", fetch_req); end
  endtask

  task automatic test_three_byte();
    adv_cnt = 0;
    len = 2'd2;
    fetch_byte(8'h10, 2);  // -> DEC
    checks++; if ({fetch_req, d1} !== 9'h000) begin failures++; $display("FAIL f3_dec got=%h want=000", {fetch_req, d1}); end
    tick();                // DEC latches length 2 -> F_D1
    len = 2'd0;            // later changes must be ignored
    fetch_byte(8'hAA, 2);
    fetch_byte(8'h55, 2);
    tick();
    checks++; if ({insn, d1, d2} !== 24'h10AA55) begin failures++; $display("FAIL f3_bytes got=%h want=10aa55", {insn, d1, d2}); end
    checks++; if (adv_cnt !== 3) begin failures++; $display("FAIL f3_adv got=%0d want=3", adv_cnt); end
    checks++; if ({fetch_req, busy, is_q} !== 5'b01000) begin failures++; $display("FAIL f3_exec got=%b want=01000", {fetch_req, busy, is_q}); end
  endtask

  task automatic test_overflow();
    pc_lrc = 1'b1;
    tick();
    pc_lrc = 1'b0;
    checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL lrc_req got=%b want=1", fetch_req); end
    fetch_ack = 1'b1; fetch_data = 8'h77; len = 2'd0;
    tick();
    fetch_ack = 1'b0;
    tick();
    checks++; if ({insn, d1, d2} !== 24'h770000) begin failures++; $display("FAIL clr_bytes got=%h want=770000", {insn, d1, d2}); end
    pc_cub = 1'b1;
    repeat (7) tick();
    checks++; if ({busy, is_q} !== 4'b1111) begin failures++; $display("FAIL ovf_pre got=%b want=1111", {busy, is_q}); end
    tick();
    pc_cub = 1'b0;
    checks++; if ({busy, fetch_req, fault, is_q} !== 7'b0011111) begin failures++; $display("FAIL ovf_halt got=%b want=0011111", {busy, fetch_req, fault, is_q}); end
    fetch_ack = 1'b1; fetch_data = 8'hEE; trap = 1'b1;
    tick();
    fetch_ack = 1'b0; trap = 1'b0;
    checks++; if ({pc_adv, busy, fault, insn} !== 12'h377) begin failures++; $display("FAIL halt_ign got=%h want=377", {pc_adv, busy, fault, insn}); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if ({busy, fetch_req, fault, is_q} !== 7'b1100000) begin failures++; $display("FAIL ovf_resume got=%b want=1100000", {busy, fetch_req, fault, is_q}); end
  endtask

  task automatic test_trap();
    fetch_ack = 1'b1; fetch_data = 8'h21; trap = 1'b1;  // trap ignored in F_OP
    tick();
    fetch_ack = 1'b0; trap = 1'b0; len = 2'd0;
    checks++; if ({busy, fault, insn} !== 11'h421) begin failures++; $display("FAIL trap_ign got=%h want=421", {busy, fault, insn}); end
    tick();  // EXEC
    pc_cub = 1'b1;
    tick();
    pc_cub = 1'b0; trap = 1'b1; pc_ini = 1'b1;
    tick();
    trap = 1'b0; pc_ini = 1'b0;
    checks++; if ({busy, fault, is_q} !== 6'b001001) begin failures++; $display("FAIL trap_halt got=%b want=001001", {busy, fault, is_q}); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if ({fetch_req, fault} !== 3'b100) begin failures++; $display("FAIL trap_resume got=%b want=100", {fetch_req, fault}); end
  endtask

  task automatic test_illegal_len();
    fetch_ack = 1'b1; fetch_data = 8'hFF;
    tick();
    fetch_ack = 1'b0; len = 2'd3;
    tick();
    len = 2'd0;
    checks++; if ({busy, fetch_req, fault, insn} !== 12'h2FF) begin failures++; $display("FAIL ill_halt got=%h want=2ff", {busy, fetch_req, fault, insn}); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if ({fetch_req, fault} !== 3'b100) begin failures++; $display("FAIL ill_resume got=%b want=100", {fetch_req, fault}); end
  endtask

  task automatic test_async_reset();
    len = 2'd1;
    fetch_ack = 1'b1; fetch_data = 8'h10;
    tick();
    fetch_ack = 1'b0;
    tick();  // F_D1, ack pending
    checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL d1_req got=%b want=1", fetch_req); end
    #3 rst = 1'b1;
    #1;
    checks++; if ({fetch_req, pc_adv, busy} !== 3'b001) begin failures++; $display("FAIL arst_ctl got=%b want=001", {fetch_req, pc_adv, busy}); end
    checks++; if ({insn, d1, d2, is_q, fault} !== 29'd0) begin failures++; $display("FAIL arst_data got=%h want=0", {insn, d1, d2, is_q, fault}); end
    fetch_ack = 1'b1; fetch_data = 8'h99;
    @(posedge clk); #1;
    fetch_ack = 1'b0; rst = 1'b0; len = 2'd0;
    tick();  // RST -> F_OP
    checks++; if ({fetch_req, pc_adv, insn} !== 10'h200) begin failures++; $display("FAIL refetch got=%h want=200", {fetch_req, pc_adv, insn}); end
    fetch_ack = 1'b1; fetch_data = 8'h3C;
    tick();
    fetch_ack = 1'b0;
    checks++; if (insn !== 8'h3C) begin failures++; $display("FAIL refetch_insn got=%h want=3c", insn); end
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_exec_steps();
    test_three_byte();
    test_overflow();
    test_trap();
    test_illegal_len();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
# fetch_seq

Instruction fetch and microcode step sequencer that drives the decoder block's `insn`, `d1`, `d2` and `is` inputs. It fetches the opcode and up to two operand bytes over a byte-wide ready/ack handshake, then advances the microcode step under control of the decoder's `pc_cub`, `pc_ini` and `pc_lrc` lines. It halts on `trap`, on an illegal length and on step overflow, and resumes on an external pulse. It sits between the instruction memory port and the decoder in the ECU.

## Interface
- `SINGLE_STEP` default: none. Compile-time only; see Configuration.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `fetch_req` out 1: byte fetch request; held high while waiting.
- `fetch_ack` in 1: memory has `fetch_data` valid. A transfer occurs on a rising edge with `fetch_req && fetch_ack`.
- `fetch_data` in 8: fetched byte.
- `pc_adv` out 1: one-cycle pulse per accepted byte; the PC increments on it.
- `len` in 2: instruction length from the decoder (0: 1 B, 1: 2 B, 2: 3 B, 3: illegal).
- `pc_cub`, `pc_ini`, `pc_lrc`, `trap` in 1 each: decoder control lines.
- `resume` in 1: leave HALT; one-cycle pulse.
- `insn`, `d1`, `d2` out 8 each: registered instruction bytes to the decoder.
- `is` out 3: microcode step.
- `busy` out 1: high in every state except HALT.
- `fault` out 2: 0 none, 1 trap, 2 illegal len, 3 step overflow. Holds its value until `resume`.

## Operation
- States:
  - RST: one cycle after reset release.
  - F_OP: fetch the opcode byte.
  - DEC: wait one cycle for `len`.
  - F_D1 and F_D2: fetch operand bytes.
  - EXEC: step through microcode.
  - HALT: stopped after a fault.
- Reset values:
  - State RST.
  - `insn`, `d1`, `d2`, `is`, `fault` are 0.
  - `fetch_req`, `pc_adv` are 0.
  - `busy` is 1.
- State transitions:
  - RST → F_OP unconditionally.
  - F_OP: `fetch_req`=1. On transfer, `insn`←`fetch_data`, `d1`←0, `d2`←0, `is`←0, `pc_adv` pulses, then DEC.
  - DEC: `len`=0 → EXEC. `len`=1 or 2 → F_D1. `len`=3 → HALT with `fault`=2.
  - F_D1: on transfer, `d1`←`fetch_data`. Then F_D2 if the latched length is 2, otherwise EXEC.
  - F_D2: on transfer, `d2`←`fetch_data`, then EXEC.
  - EXEC: `is` starts at 0.
    - `pc_cub`: `is`←`is`+1.
    - `pc_ini` or `pc_lrc`: `is`←0, then F_OP.
    - None of the three asserted: `is` holds (microcode wait state).
    - `pc_cub` at `is`=7: no wrap; HALT with `fault`=3.
  - HALT: `fetch_req`=0, `busy`=0, `is` and the instruction bytes hold. `resume` → F_OP, `fault`←0, `is`←0.
- `len` is latched in DEC into an internal 2-bit register. Later changes on `len` are ignored until the next DEC.
- Priority in EXEC: `trap` > overflow > `pc_lrc` > `pc_ini` > `pc_cub`. `trap` → HALT with `fault`=1.
- `trap` is honoured only in EXEC; in other states it is ignored.
- `resume` outside HALT is ignored.
- `fetch_ack` without `fetch_req` is ignored, and `pc_adv` is not pulsed.

## Timing
- Byte capture occurs on the edge of the transfer; `pc_adv` is high in the following cycle only.
- `fetch_req` drops in the cycle after a transfer.
- Minimum instruction overhead before EXEC, with zero-wait memory:
  - 1-byte instruction: 2 cycles (F_OP, DEC).
  - 3-byte instruction: 4 cycles.
- `is` updates one edge after `pc_cub` is sampled. The decoder samples `is` on the falling edge, so it sees the new step half a cycle later.
- EXEC → F_OP takes one edge, so `fetch_req` is high in the cycle after `pc_ini`.
- `rst` asserted mid-fetch or mid-EXEC forces the reset values immediately, independent of `clk`. A pending handshake is abandoned.

## Configuration
- `FETCH_SEQ_SINGLE_STEP_EN` defined:
  - Adds input `step_en` (1 bit).
  - On `pc_ini` or `pc_lrc` the FSM enters HALT with `fault`=0 instead of F_OP.
  - `resume` then proceeds to F_OP.
  - When `step_en`=0, behaviour is identical to the macro being undefined.
- `FETCH_SEQ_SINGLE_STEP_EN` undefined: no `step_en` port, and the single-step path is absent.

## Test plan
- Reset, then 1-byte opcode 0x3C with immediate ack and `len`=0 → `insn`=0x3C, `d1`=`d2`=0, EXEC on cycle 3, `is`=0.
- 3-byte instruction 0x10,0xAA,0x55 with a 2-cycle ack delay per byte and `len`=2 → `d1`=0xAA, `d2`=0x55, exactly three `pc_adv` pulses.
- EXEC with `pc_cub` for 3 cycles, then `pc_ini` → `is` goes 1,2,3, then 0. `fetch_req` is high the next cycle.
- `pc_cub` held 8 cycles → HALT with `fault`=3 at `is`=7 and `busy`=0. `resume` → F_OP with `fault`=0.
- `trap` and `pc_ini` in the same cycle → HALT with `fault`=1. `len`=3 in DEC → HALT with `fault`=2.
- `rst` pulsed mid-F_D1 while ack is pending → all outputs return to their reset values asynchronously. Refetch starts in F_OP after RST.
